// File: rtl/fifo_param_pkg.sv
// Shared default sizing for the FIFO storage block.
package fifo_param_pkg;
  parameter int unsigned FIFO_WIDTH = 8;
  parameter int unsigned FIFO_DEPTH = 16;
endpackage

// File: rtl/fifo_mem.sv
// Circular-buffer FIFO storage with wrap-bit pointers, registered read data
// and one-cycle error pulses for rejected accesses.
module fifo_mem #(
  parameter int unsigned FIFO_WIDTH = fifo_param_pkg::FIFO_WIDTH,
  parameter int unsigned FIFO_DEPTH = fifo_param_pkg::FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  mem_wr_en,
  input  logic [FIFO_WIDTH-1:0] fifo_wr_data,
  input  logic                  mem_rd_en,
  output logic [FIFO_WIDTH-1:0] fifo_rd_data,
  output logic                  mem_full,
  output logic                  mem_empty,
  output logic                  mem_wr_err,
  output logic                  mem_rd_err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic [FIFO_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  wr_err_q, wr_err_d;
  logic                  rd_err_q, rd_err_d;

  logic                  rd_acc;
  logic                  wr_acc;

  assign mem_empty = (wr_ptr_q == rd_ptr_q);
  assign mem_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                     (wr_ptr_q[AW] != rd_ptr_q[AW]);

  // A read frees a slot in the same cycle, so a full FIFO still accepts a write.
  assign rd_acc = mem_rd_en && !mem_empty;
  assign wr_acc = mem_wr_en && (!mem_full || rd_acc);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_data_d = rd_data_q;
    wr_err_d  = mem_wr_en && !wr_acc;
    rd_err_d  = mem_rd_en && mem_empty;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end
    if (rd_acc) begin
      rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, 1'b1};
      rd_data_d = mem_q[rd_ptr_q[AW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
      wr_err_q  <= 1'b0;
      rd_err_q  <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_data_q <= rd_data_d;
      wr_err_q  <= wr_err_d;
      rd_err_q  <= rd_err_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q[AW-1:0]] <= fifo_wr_data;
    end
  end

  assign fifo_rd_data = rd_data_q;
  assign mem_wr_err   = wr_err_q;
  assign mem_rd_err   = rd_err_q;

endmodule

// File: tb/tb_fifo_mem.sv
// Self-checking bench for fifo_mem against a queue-based FIFO reference model.
module tb_fifo_mem;
  localparam int unsigned W = 8;
  localparam int unsigned D = 16;

  logic         clk = 1'b0;
  logic         n_rst = 1'b1;
  logic         mem_wr_en = 1'b0;
  logic [W-1:0] fifo_wr_data = '0;
  logic         mem_rd_en = 1'b0;
  logic [W-1:0] fifo_rd_data;
  logic         mem_full, mem_empty, mem_wr_err, mem_rd_err;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [W-1:0] q[$];
  logic [W-1:0] exp_rd = '0;
  logic         exp_wr_err = 1'b0;
  logic         exp_rd_err = 1'b0;

  fifo_mem #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk(clk), .n_rst(n_rst), .mem_wr_en(mem_wr_en), .fifo_wr_data(fifo_wr_data),
    .mem_rd_en(mem_rd_en), .fifo_rd_data(fifo_rd_data), .mem_full(mem_full),
    .mem_empty(mem_empty), .mem_wr_err(mem_wr_err), .mem_rd_err(mem_rd_err)
  );

  always #5 clk = ~clk;

  function automatic bit exp_full();
    return q.size() == D;
  endfunction

  function automatic bit exp_empty();
    return q.size() == 0;
  endfunction

  task automatic model_reset();
    q.delete();
    exp_rd = '0;
    exp_wr_err = 1'b0;
    exp_rd_err = 1'b0;
  endtask

  // Applies one cycle of stimulus and advances the model; called at posedge+1.
  task automatic step(input bit wr, input logic [W-1:0] d, input bit rd);
    bit full, empty, rd_ok, wr_ok;
    mem_wr_en = wr;
    fifo_wr_data = d;
    mem_rd_en = rd;
    full = exp_full();
    empty = exp_empty();
    rd_ok = rd && !empty;
    wr_ok = wr && (!full || rd_ok);
    if (rd_ok) exp_rd = q.pop_front();
    if (wr_ok) q.push_back(d);
    exp_wr_err = wr && !wr_ok;
    exp_rd_err = rd && empty;
    @(posedge clk);
    #1;
    mem_wr_en = 1'b0;
    mem_rd_en = 1'b0;
  endtask

  task automatic test_reset();
    #2 n_rst = 1'b0;
    #2;
    vectors++;
    if (mem_empty !== 1'b1 || mem_full !== 1'b0 || fifo_rd_data !== '0 ||
        mem_wr_err !== 1'b0 || mem_rd_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: empty=%b full=%b rd=%h werr=%b rerr=%b, want 1 0 00 0 0",
               mem_empty, mem_full, fifo_rd_data, mem_wr_err, mem_rd_err);
    end
    model_reset();
    @(posedge clk);
    #1 n_rst = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, W'(i), 1'b0);
      vectors++;
      if (mem_full !== exp_full() || mem_empty !== 1'b0 || mem_wr_err !== 1'b0) begin
        miscompares++;
        $display("FAIL fill[%0d]: full=%b empty=%b werr=%b, want full=%b empty=0 werr=0",
                 i, mem_full, mem_empty, mem_wr_err, exp_full());
      end
    end
    vectors++;
    if (mem_full !== 1'b1) begin
      miscompares++;
      $display("FAIL fill_full: full=%b, want 1", mem_full);
    end
    step(1'b1, 8'hFF, 1'b0);
    vectors++;
    if (mem_wr_err !== 1'b1 || mem_full !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_err: werr=%b full=%b, want 1 1", mem_wr_err, mem_full);
    end
    step(1'b0, '0, 1'b0);
    vectors++;
    if (mem_wr_err !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_pulse: werr=%b, want 0", mem_wr_err);
    end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, '0, 1'b1);
      vectors++;
      if (fifo_rd_data !== exp_rd || fifo_rd_data !== W'(i) || mem_rd_err !== 1'b0) begin
        miscompares++;
        $display("FAIL drain[%0d]: rd=%h rerr=%b, want rd=%h rerr=0",
                 i, fifo_rd_data, mem_rd_err, exp_rd);
      end
    end
    vectors++;
    if (mem_empty !== 1'b1 || mem_full !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_empty: empty=%b full=%b, want 1 0", mem_empty, mem_full);
    end
    step(1'b0, '0, 1'b1);
    vectors++;
    if (mem_rd_err !== 1'b1 || fifo_rd_data !== 8'h10) begin
      miscompares++;
      $display("FAIL underflow: rerr=%b rd=%h, want 1 10", mem_rd_err, fifo_rd_data);
    end
    step(1'b0, '0, 1'b0);
    vectors++;
    if (mem_rd_err !== 1'b0) begin
      miscompares++;
      $display("FAIL underflow_pulse: rerr=%b, want 0", mem_rd_err);
    end
  endtask

  task automatic test_full_rw();
    for (int i = 1; i <= 16; i++) step(1'b1, W'(i), 1'b0);
    step(1'b1, 8'hAA, 1'b1);
    vectors++;
    if (fifo_rd_data !== 8'h01 || mem_full !== 1'b1 || mem_wr_err !== 1'b0 ||
        mem_rd_err !== 1'b0) begin
      miscompares++;
      $display("FAIL full_rw: rd=%h full=%b werr=%b rerr=%b, want 01 1 0 0",
               fifo_rd_data, mem_full, mem_wr_err, mem_rd_err);
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, '0, 1'b1);
      vectors++;
      if (fifo_rd_data !== exp_rd) begin
        miscompares++;
        $display("FAIL full_rw_drain[%0d]: rd=%h, want %h", i, fifo_rd_data, exp_rd);
      end
    end
    vectors++;
    if (fifo_rd_data !== 8'hAA || mem_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL full_rw_last: rd=%h empty=%b, want AA 1", fifo_rd_data, mem_empty);
    end
  endtask

  task automatic test_empty_rw();
    step(1'b1, 8'h55, 1'b1);
    vectors++;
    if (mem_rd_err !== 1'b1 || fifo_rd_data !== 8'hAA || mem_empty !== 1'b0 ||
        mem_wr_err !== 1'b0) begin
      miscompares++;
      $display("FAIL empty_rw: rerr=%b rd=%h empty=%b werr=%b, want 1 AA 0 0",
               mem_rd_err, fifo_rd_data, mem_empty, mem_wr_err);
    end
    step(1'b0, '0, 1'b1);
    vectors++;
    if (fifo_rd_data !== 8'h55 || mem_rd_err !== 1'b0 || mem_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL empty_rw_read: rd=%h rerr=%b empty=%b, want 55 0 1",
               fifo_rd_data, mem_rd_err, mem_empty);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 40; i++) begin
      step(1'b1, W'(8'h60 + i), 1'b0);
      step(1'b0, '0, 1'b1);
      vectors++;
      if (fifo_rd_data !== W'(8'h60 + i) || mem_empty !== 1'b1 || mem_rd_err !== 1'b0) begin
        miscompares++;
        $display("FAIL wrap[%0d]: rd=%h empty=%b rerr=%b, want %h 1 0",
                 i, fifo_rd_data, mem_empty, mem_rd_err, W'(8'h60 + i));
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) step(1'b1, W'(8'hC0 + i), 1'b0);
    step(1'b0, '0, 1'b1);
    #3 n_rst = 1'b0;
    #1;
    vectors++;
    if (mem_empty !== 1'b1 || mem_full !== 1'b0 || fifo_rd_data !== '0 ||
        mem_wr_err !== 1'b0 || mem_rd_err !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: empty=%b full=%b rd=%h werr=%b rerr=%b, want 1 0 00 0 0",
               mem_empty, mem_full, fifo_rd_data, mem_wr_err, mem_rd_err);
    end
    model_reset();
    #1 n_rst = 1'b1;
    step(1'b0, '0, 1'b1);
    vectors++;
    if (mem_rd_err !== 1'b1 || fifo_rd_data !== '0 || mem_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset_read: rerr=%b rd=%h empty=%b, want 1 00 1",
               mem_rd_err, fifo_rd_data, mem_empty);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      int unsigned bias;
      bias = (i / 100) % 2 == 0 ? 70 : 30;
      step(($urandom_range(99) < bias), W'($urandom), ($urandom_range(99) >= bias));
      vectors++;
      if (fifo_rd_data !== exp_rd || mem_full !== exp_full() || mem_empty !== exp_empty() ||
          mem_wr_err !== exp_wr_err || mem_rd_err !== exp_rd_err) begin
        miscompares++;
        $display("FAIL random[%0d]: rd=%h full=%b empty=%b werr=%b rerr=%b, want %h %b %b %b %b",
                 i, fifo_rd_data, mem_full, mem_empty, mem_wr_err, mem_rd_err,
                 exp_rd, exp_full(), exp_empty(), exp_wr_err, exp_rd_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_full_rw();
    test_empty_rw();
    test_wrap();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_mem.md
FIFO_MEM -- requirements
Module: fifo_mem

Interface
REQ-001 The block SHALL take parameter FIFO_WIDTH, default 8, data word width in bits, imported from fifo_param_pkg.
REQ-002 The block SHALL take parameter FIFO_DEPTH, default 16, number of entries, power of two and at least 2.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port n_rst, input, 1, reset, asynchronous and active-low.
REQ-005 The block SHALL have port mem_wr_en, input, 1, write request from the write controller.
REQ-006 The block SHALL have port fifo_wr_data, input, FIFO_WIDTH, data to store on an accepted write.
REQ-007 The block SHALL have port mem_rd_en, input, 1, read request from the read controller.
REQ-008 The block SHALL have port fifo_rd_data, output, FIFO_WIDTH, registered read data.
REQ-009 The block SHALL have port mem_full, output, 1, high when occupancy equals FIFO_DEPTH.
REQ-010 The block SHALL have port mem_empty, output, 1, high when occupancy equals 0.
REQ-011 The block SHALL have port mem_wr_err, output, 1, one-cycle pulse flagging a rejected write.
REQ-012 The block SHALL have port mem_rd_err, output, 1, one-cycle pulse flagging a rejected read.

Function
REQ-013 Storage SHALL be a FIFO_DEPTH x FIFO_WIDTH circular buffer with wr_ptr and rd_ptr of log2(FIFO_DEPTH)+1 bits each; the MSB is the wrap bit.
REQ-014 mem_empty SHALL be 1 exactly when wr_ptr == rd_ptr (all bits), and is driven combinationally from registered pointers.
REQ-015 mem_full SHALL be 1 exactly when the index bits are equal and the wrap bits differ.
REQ-016 A write SHALL be accepted when mem_wr_en=1 and either mem_full=0 or a read is accepted in the same cycle.
REQ-017 An accepted write SHALL store fifo_wr_data at mem[wr_ptr index] and increment wr_ptr modulo 2*FIFO_DEPTH.
REQ-018 A read SHALL be accepted when mem_rd_en=1 and mem_empty=0; there is no write-to-read bypass when empty.
REQ-019 An accepted read SHALL load fifo_rd_data with mem[rd_ptr index] on the same clock edge, so data is valid the cycle after the request (latency 1), and rd_ptr increments modulo 2*FIFO_DEPTH.
REQ-020 fifo_rd_data SHALL hold its previous value in every cycle without an accepted read.
REQ-021 mem_wr_err SHALL be registered high for exactly one cycle after a cycle with mem_wr_en=1 and the write not accepted, and is 0 otherwise.
REQ-022 mem_rd_err SHALL be registered high for exactly one cycle after a cycle with mem_rd_en=1 and mem_empty=1, and is 0 otherwise.
REQ-023 A rejected access SHALL change neither pointer nor memory contents.
REQ-024 With simultaneous accepted read and write, occupancy SHALL be unchanged and mem_full/mem_empty SHALL keep their values.
REQ-025 When full, simultaneous read and write SHALL both be accepted, the read returning the oldest entry.
REQ-026 When empty, simultaneous read and write SHALL accept the write, reject the read with mem_rd_err, and leave fifo_rd_data unchanged.
REQ-027 Pointer wrap-around SHALL be seamless; data order SHALL be strictly first-in first-out across any number of wraps.

Reset
REQ-028 While n_rst=0, independent of clk: wr_ptr=0, rd_ptr=0, fifo_rd_data=0, mem_wr_err=0, mem_rd_err=0, giving mem_empty=1 and mem_full=0.
REQ-029 Memory array contents SHALL NOT be reset.
REQ-030 Reset asserted mid-operation SHALL discard all stored entries; the first read after release SHALL be rejected until a write is accepted.

Verification
REQ-031 Reset, then 16 writes of 0x01..0x10 -> mem_full=1 after the 16th write, mem_empty=0; a 17th write of 0xFF -> mem_wr_err pulses once and contents are unchanged.
REQ-032 From full, 16 reads -> fifo_rd_data = 0x01..0x10 in order, each one cycle after its request; mem_empty=1 after the last; one more read -> mem_rd_err pulse and fifo_rd_data stays 0x10.
REQ-033 Full FIFO with read and write (0xAA) in the same cycle -> read returns 0x01, mem_full stays 1, no error, and 0xAA is read out after 0x10.
REQ-034 Empty FIFO with read and write (0x55) in the same cycle -> mem_rd_err pulses, fifo_rd_data unchanged, mem_empty=0 next cycle, and the next read returns 0x55.
REQ-035 40 alternating write/read pairs with incrementing data -> both pointers wrap twice and every read returns the value written 1 entry earlier.
REQ-036 n_rst pulsed low between clk edges with 5 entries stored -> outputs go to reset values immediately, mem_empty=1, and a read after release flags mem_rd_err.
